// File: rtl/alu_exec_unit_if.sv
// Request/result bundle between the issuing stage (master) and alu_exec_unit (slave).
// Carries the valid/ready handshake, the operation code, both operands and the registered results.
interface alu_exec_unit_if #(
    parameter int DATA_W = 32
);
    logic              valid_i;
    logic              ready_o;
    logic [3:0]        ALUCtrl_i;
    logic [DATA_W-1:0] src1_i;
    logic [DATA_W-1:0] src2_i;
    logic [DATA_W-1:0] result_o;
    logic              zero_o;
    logic              overflow_o;
    logic              done_o;

    modport master (
        output valid_i, ALUCtrl_i, src1_i, src2_i,
        input  ready_o, result_o, zero_o, overflow_o, done_o
    );

    modport slave (
        input  valid_i, ALUCtrl_i, src1_i, src2_i,
        output ready_o, result_o, zero_o, overflow_o, done_o
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Registered ALU execution unit: single-cycle logic/arithmetic, optional iterative multiplier.
// Define ALU_MUL_EN to build the shift-add multiplier (code 1000, DATA_W+1 cycle latency).
module alu_exec_unit #(
    parameter int DATA_W = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    alu_exec_unit_if.slave bus
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1101;
    localparam int         MSB     = DATA_W - 1;

    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              overflow_q, overflow_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] sum, diff, alu_res;
    logic              slt_bit, alu_ovf;
    logic              ready, accept;

`ifdef ALU_MUL_EN
    localparam logic [3:0]       OP_MUL     = 4'b1000;
    localparam logic [0:0]       ST_IDLE    = 1'b0;
    localparam logic [0:0]       ST_MUL_RUN = 1'b1;
    localparam int               CNT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DATA_W - 1);

    logic [0:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [2*DATA_W-1:0] acc_step;

    assign ready    = (state_q == ST_IDLE);
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : {(2*DATA_W){1'b0}});
`else
    assign ready    = 1'b1;
`endif

    assign accept = bus.valid_i && ready;

    // Single-cycle result and overflow for the code currently presented.
    always_comb begin
        sum     = bus.src1_i + bus.src2_i;
        diff    = bus.src1_i - bus.src2_i;
        // Differing signs decide SLT directly, so an overflowing A-B cannot flip it.
        slt_bit = (bus.src1_i[MSB] != bus.src2_i[MSB]) ? bus.src1_i[MSB] : diff[MSB];
        alu_res = {DATA_W{1'b0}};
        alu_ovf = 1'b0;
        case (bus.ALUCtrl_i)
            OP_AND:  alu_res = bus.src1_i & bus.src2_i;
            OP_OR:   alu_res = bus.src1_i | bus.src2_i;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = add_ovf(bus.src1_i[MSB], bus.src2_i[MSB], sum[MSB]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = sub_ovf(bus.src1_i[MSB], bus.src2_i[MSB], diff[MSB]);
            end
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, slt_bit};
            OP_NOR:  alu_res = ~(bus.src1_i | bus.src2_i);
            OP_NAND: alu_res = ~(bus.src1_i & bus.src2_i);
            default: begin
                alu_res = {DATA_W{1'b0}};
                alu_ovf = 1'b0;
            end
        endcase
    end

    // Next-state for outputs and, when built, the multiplier sequencer.
    always_comb begin
        result_d   = result_q;
        zero_d     = zero_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
`ifdef ALU_MUL_EN
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        if (state_q == ST_MUL_RUN) begin
            acc_d    = acc_step;
            mcand_d  = {mcand_q[2*DATA_W-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[DATA_W-1:1]};
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
                state_d    = ST_IDLE;
                cnt_d      = {CNT_W{1'b0}};
                result_d   = acc_step[DATA_W-1:0];
                zero_d     = (acc_step[DATA_W-1:0] == {DATA_W{1'b0}});
                overflow_d = |acc_step[2*DATA_W-1:DATA_W];
                done_d     = 1'b1;
            end else begin
                state_d    = ST_MUL_RUN;
            end
        end else if (accept) begin
            if (bus.ALUCtrl_i == OP_MUL) begin
                state_d  = ST_MUL_RUN;
                cnt_d    = {CNT_W{1'b0}};
                acc_d    = {(2*DATA_W){1'b0}};
                mcand_d  = {{DATA_W{1'b0}}, bus.src1_i};
                mplier_d = bus.src2_i;
            end else begin
                result_d   = alu_res;
                zero_d     = (alu_res == {DATA_W{1'b0}});
                overflow_d = alu_ovf;
                done_d     = 1'b1;
            end
        end else begin
            state_d = ST_IDLE;
        end
`else
        if (accept) begin
            result_d   = alu_res;
            zero_d     = (alu_res == {DATA_W{1'b0}});
            overflow_d = alu_ovf;
            done_d     = 1'b1;
        end else begin
            done_d     = 1'b0;
        end
`endif
    end

    // Output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_q   <= {DATA_W{1'b0}};
            zero_q     <= 1'b1;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            result_q   <= result_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

`ifdef ALU_MUL_EN
    // Multiplier sequencer registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            acc_q    <= {(2*DATA_W){1'b0}};
            mcand_q  <= {(2*DATA_W){1'b0}};
            mplier_q <= {DATA_W{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end
`endif

    assign bus.ready_o    = ready;
    assign bus.result_o   = result_q;
    assign bus.zero_o     = zero_q;
    assign bus.overflow_o = overflow_q;
    assign bus.done_o     = done_q;
endmodule
